// File: rtl/display_scan.sv
// rtl/display_scan.sv - four-digit multiplexed seven-segment display scanner
//
// Dwells PRESCALE clk cycles on each digit, cycling thousands -> hundreds ->
// tens -> ones. s selects the digit one dwell ahead of the digit shown, so
// digit_in is already settled when it is captured on the tick edge.
//
// Optional feature: define BLANK_LEAD_ZERO_EN to blank leading zeros in the
// thousands and hundreds positions (seg_digit code 11).
//
// Ports:
//   clk        in   1  clock, rising edge
//   reset_n    in   1  asynchronous active-low reset
//   en         in   1  scan enable
//   digit_in   in   4  digit code from the external mux for the current s
//   s          out  3  digit select to the external mux (4,3,1,0)
//   seg_digit  out  4  digit code to the segment decoder, 11 = blank
//   an_n       out  4  active-low digit enables (bit3 thousands .. bit0 ones)
//   tick       out  1  one-cycle pulse at each dwell terminal count
module display_scan #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [3:0] digit_in,
    output logic [2:0] s,
    output logic [3:0] seg_digit,
    output logic [3:0] an_n,
    output logic       tick
);

    typedef enum logic [1:0] {
        THOUS,
        HUNDR,
        TENS,
        ONES
    } state_t;

    localparam logic [3:0]  BLANK = 4'd11;
    localparam logic [19:0] LAST  = 20'(PRESCALE - 1);

    logic [19:0] count;
    logic [19:0] count_nxt;
    state_t      state;
    state_t      state_nxt;
    logic [3:0]  seg_nxt;

`ifdef BLANK_LEAD_ZERO_EN
    logic lead_zero;
    logic lead_zero_nxt;
`endif

    function automatic logic [2:0] sel_code(input state_t st);
        case (st)
            THOUS:   sel_code = 3'd4;
            HUNDR:   sel_code = 3'd3;
            TENS:    sel_code = 3'd1;
            default: sel_code = 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] an_code(input state_t st);
        case (st)
            THOUS:   an_code = 4'b0111;
            HUNDR:   an_code = 4'b1011;
            TENS:    an_code = 4'b1101;
            default: an_code = 4'b1110;
        endcase
    endfunction

    always_comb begin
        count_nxt = (count == LAST) ? 20'd0 : count + 20'd1;
    end

    always_comb begin
        case (state)
            THOUS:   state_nxt = HUNDR;
            HUNDR:   state_nxt = TENS;
            TENS:    state_nxt = ONES;
            default: state_nxt = THOUS;
        endcase
    end

    // Value captured into seg_digit at the next tick edge.
    always_comb begin
        seg_nxt = digit_in;
`ifdef BLANK_LEAD_ZERO_EN
        lead_zero_nxt = lead_zero;
        case (state)
            THOUS: begin
                if (digit_in == 4'd0) seg_nxt = BLANK;
                else                  lead_zero_nxt = 1'b0;
            end
            HUNDR: begin
                if (lead_zero && digit_in == 4'd0) seg_nxt = BLANK;
                else                               lead_zero_nxt = 1'b0;
            end
            ONES:    lead_zero_nxt = 1'b1;
            default: ;
        endcase
`endif
    end

    // tick is registered from the next count value so it is high exactly in
    // the cycle where count sits at its terminal value; the state machine
    // then advances on the edge that ends that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count     <= 20'd0;
            tick      <= 1'b0;
            state     <= THOUS;
            s         <= 3'd4;
            an_n      <= 4'b1111;
            seg_digit <= BLANK;
`ifdef BLANK_LEAD_ZERO_EN
            lead_zero <= 1'b1;
`endif
        end else if (!en) begin
            count <= 20'd0;
            tick  <= 1'b0;
            an_n  <= 4'b1111;
        end else begin
            count <= count_nxt;
            tick  <= (count_nxt == LAST);
            if (tick) begin
                state     <= state_nxt;
                s         <= sel_code(state_nxt);
                seg_digit <= seg_nxt;
                an_n      <= an_code(state);
`ifdef BLANK_LEAD_ZERO_EN
                lead_zero <= lead_zero_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// tb/tb_display_scan.sv - randomized bench for display_scan against a reference model
module tb_display_scan;

    localparam int NI = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic [3:0] digit_in;
    logic [2:0] s4, s1;
    logic [3:0] seg4, seg1, an4, an1;
    logic       tick4, tick1;

    display_scan #(.PRESCALE(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .en(en), .digit_in(digit_in),
        .s(s4), .seg_digit(seg4), .an_n(an4), .tick(tick4)
    );

    display_scan #(.PRESCALE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .en(en), .digit_in(digit_in),
        .s(s1), .seg_digit(seg1), .an_n(an1), .tick(tick1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: position index 0..3 = thousands..ones, r = number of
    // consecutive enabled edges since reset or disable.
    int         pre[NI]      = '{4, 1};
    int         code[4]      = '{4, 3, 1, 0};
    logic [3:0] onehot_n[4]  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    int         r[NI];
    int         idx[NI];
    int         mseg[NI];
    bit         flag[NI];
    bit         mtk[NI];
    logic [3:0] man[NI];
    int         digits[4];

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            r[i] = 0; mtk[i] = 0; idx[i] = 0;
            man[i] = 4'b1111; mseg[i] = 11; flag[i] = 1;
        end
    endtask

    task automatic capture(input int i, input logic [3:0] d);
        mseg[i] = int'(d);
`ifdef BLANK_LEAD_ZERO_EN
        if (idx[i] == 0) begin
            if (d == 4'd0) mseg[i] = 11;
            else           flag[i] = 0;
        end else if (idx[i] == 1) begin
            if (flag[i] && d == 4'd0) mseg[i] = 11;
            else                      flag[i] = 0;
        end else if (idx[i] == 3) begin
            flag[i] = 1;
        end
`endif
    endtask

    task automatic model_edge(input logic e, input logic [3:0] d);
        for (int i = 0; i < NI; i++) begin
            if (!e) begin
                r[i] = 0; mtk[i] = 0; man[i] = 4'b1111;
            end else begin
                if (mtk[i]) begin
                    capture(i, d);
                    man[i] = onehot_n[idx[i]];
                    idx[i] = (idx[i] + 1) % 4;
                end
                r[i]++;
                mtk[i] = (r[i] % pre[i]) == pre[i] - 1;
            end
        end
    endtask

    task automatic check_all();
        chk("s_p4",    32'(s4),    32'(code[idx[0]]));
        chk("an_p4",   32'(an4),   32'(man[0]));
        chk("seg_p4",  32'(seg4),  32'(mseg[0]));
        chk("tick_p4", 32'(tick4), 32'(mtk[0]));
        chk("s_p1",    32'(s1),    32'(code[idx[1]]));
        chk("an_p1",   32'(an1),   32'(man[1]));
        chk("seg_p1",  32'(seg1),  32'(mseg[1]));
        chk("tick_p1", 32'(tick1), 32'(mtk[1]));
    endtask

    // Starts and ends at a falling edge. digit_in carries the muxed digit only
    // at P=4 tick edges; elsewhere it is random and must be ignored.
    task automatic cycle(input bit e);
        check_all();
        en = e;
        if (mtk[0] && e) digit_in = 4'(digits[idx[0]]);
        else             digit_in = 4'($urandom_range(0, 15));
        @(posedge clk);
        model_edge(en, digit_in);
        #2 digit_in = 4'($urandom_range(0, 15));
        @(negedge clk);
    endtask

    initial begin
        int guard;
        reset_n  = 1'b0;
        en       = 1'b0;
        digit_in = 4'd0;
        model_reset();
        digits = '{7, 7, 7, 7};
        @(negedge clk);
        check_all();
        reset_n = 1'b1;

        repeat (24) cycle(1);
        digits = '{1, 2, 3, 4};
        repeat (24) cycle(1);
        repeat (3) begin
            for (int k = 0; k < 4; k++) digits[k] = $urandom_range(0, 9);
            repeat (20) cycle(1);
        end

        // Drop enable in the middle of a dwell.
        guard = 0;
        while (r[0] % 4 != 1 && guard < 8) begin
            cycle(1);
            guard++;
        end
        repeat (5) cycle(0);
        repeat (12) cycle(1);

        digits = '{0, 0, 5, 0};
        repeat (20) cycle(1);
        digits = '{0, 3, 0, 0};
        repeat (20) cycle(1);

        for (int k = 0; k < 4; k++) digits[k] = $urandom_range(0, 2);
        repeat (150) cycle($urandom_range(0, 4) != 0);

        // Asynchronous reset between edges while showing hundreds.
        digits = '{6, 8, 9, 2};
        guard = 0;
        while (idx[0] != 1 && guard < 40) begin
            cycle(1);
            guard++;
        end
        chk("reach_hundr", 32'(s4), 32'd3);
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        check_all();
        reset_n = 1'b1;
        repeat (24) cycle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter PRESCALE, default 50000, SHALL set the clk cycles each digit dwells; legal range is 1 to 2^20-1.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 en  input  1  SHALL be the scan enable; active high.
REQ-005 digit_in  input  4  SHALL be the digit code returned by the digit multiplexer for the current s.
REQ-006 s  output  3  SHALL be the registered digit select driven to the digit multiplexer.
REQ-007 seg_digit  output  4  SHALL be the registered digit code to the seven-segment decoder; code 11 means blank.
REQ-008 an_n  output  4  SHALL be the active-low digit enables: bit3 thousands, bit2 hundreds, bit1 tens, bit0 ones.
REQ-009 tick  output  1  SHALL pulse high for one cycle at each dwell terminal count.

Function
REQ-010 The prescaler SHALL count 0..PRESCALE-1 while en=1; tick=1 in the cycle where count=PRESCALE-1; count wraps to 0 on the next edge.
REQ-011 With PRESCALE=1, tick SHALL be high every enabled cycle.
REQ-012 The FSM SHALL step through THOUS(s=4) -> HUNDR(s=3) -> TENS(s=1) -> ONES(s=0) -> THOUS; s value 2 SHALL never be driven.
REQ-013 The FSM SHALL advance only on an edge where tick=1.
REQ-014 On each tick edge, the block SHALL load seg_digit from digit_in and drive an_n to the active-low one-hot of the pre-advance state; s SHALL then take the next state's code on that same edge.
REQ-015 The displayed digit SHALL lag s by exactly one dwell period.
REQ-016 On the edge where en=0 is sampled: count clears to 0, FSM state holds, an_n is forced to 4'b1111, and seg_digit holds.
REQ-017 When en returns to 1, scanning SHALL resume from the held state; the first tick occurs PRESCALE cycles later.
REQ-018 digit_in SHALL be sampled only on tick edges; changes between ticks SHALL have no effect on outputs.
REQ-019 Exactly one an_n bit SHALL be low whenever en=1 and at least one tick has occurred since reset or since re-enable.

Reset
REQ-020 Asserting reset_n=0 SHALL immediately set: count=0, state=THOUS, s=4, an_n=4'b1111, seg_digit=11, tick=0, leading-zero flag=1.
REQ-021 Reset asserted mid-dwell SHALL abandon the dwell; after release, the first tick occurs PRESCALE enabled cycles later, capturing the thousands digit.

Configuration
REQ-022 Macro BLANK_LEAD_ZERO_EN, when defined, SHALL enable leading-zero blanking:
- At a THOUS capture with digit_in=0: seg_digit=11 and the flag stays 1; any other value clears the flag.
- At a HUNDR capture with flag=1 and digit_in=0: seg_digit=11; otherwise the flag clears.
- TENS and ONES are never blanked.
- The flag is set to 1 at each ONES capture.
REQ-023 Without BLANK_LEAD_ZERO_EN, seg_digit SHALL equal the captured digit_in unmodified, and no flag register SHALL exist.

Verification (PRESCALE=4)
REQ-024 Reset release, en=1, digit_in constant 7 -> tick every 4th cycle; s sequence 4,3,1,0,4; an_n sequence 0111,1011,1101,1110; seg_digit=7 from first tick.
REQ-025 digit_in driven per s (s4->1, s3->2, s1->3, s0->4) -> seg_digit sequence 1,2,3,4 paired with an_n 0111,1011,1101,1110.
REQ-026 en dropped mid-dwell for 5 cycles -> an_n=1111 on the next edge, s unchanged, tick=0; after re-enable, first tick 4 cycles later.
REQ-027 reset_n pulsed low asynchronously between edges during HUNDR -> outputs take reset values immediately; after release, first capture is thousands.
REQ-028 With BLANK_LEAD_ZERO_EN and digits 0,0,5,0 -> seg_digit sequence 11,11,5,0; with digits 0,3,0,0 -> 11,3,0,0; without the macro, 0,0,5,0 -> 0,0,5,0.
REQ-029 PRESCALE=1, en=1 -> tick constant high; s advances every cycle.
